// File: rtl/alt_vipitc120_common_sync_lock_controller.sv
// ITC sync-lock controller. It qualifies input timing stability, arms the sync
// generator, tracks SOF lock over frames and recovers when lock is lost. It also
// double-buffers the SOF position and divider configuration from the host.
// Optional feature macro: SYNC_LOCK_IRQ_EN adds a sticky loss-of-lock interrupt.
module alt_vipitc120_common_sync_lock_controller #(
   parameter int unsigned STABLE_FRAMES  = 2,
   parameter int unsigned LOCK_FRAMES    = 4,
   parameter int unsigned TIMEOUT_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        cfg_write,
   input  logic [2:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   input  logic        stable,
   input  logic        start_of_vsync,
   input  logic        sof,
   input  logic        sof_locked,
   output logic        clear_enable,
   output logic        output_enable,
   output logic [13:0] sof_sample,
   output logic [12:0] sof_line,
   output logic [1:0]  sof_subsample,
   output logic [13:0] divider_value,
   output logic        locked,
   output logic        lock_lost,
   output logic [2:0]  state,
   output logic        irq
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_STABLE = 3'd1,
      ARM         = 3'd2,
      ACQUIRE     = 3'd3,
      LOCKED      = 3'd4,
      RECOVER     = 3'd5
   } state_t;

   state_t      st;
   logic [3:0]  stab_cnt;
   logic [3:0]  hit_cnt;
   logic [3:0]  miss_cnt;
   logic        sof_seen;

   logic [3:0]  stab_inc;
   logic [3:0]  hit_next;
   logic [3:0]  miss_next;
   logic        frame_hit;

   logic [13:0] sh_sample;
   logic [12:0] sh_line;
   logic [1:0]  sh_subsample;
   logic [13:0] sh_divider;
   logic        pending;
   logic        shadow_wr;
   logic        commit;

   logic        unused_wdata_hi;
   assign unused_wdata_hi = ^cfg_wdata[15:14];

   assign state = st;

   // Saturating frame counters as they will stand after this cycle's vsync, if any
   always_comb begin
      frame_hit = sof_seen | sof;
      stab_inc  = (stab_cnt == 4'd15) ? 4'd15 : stab_cnt + 4'd1;
      hit_next  = hit_cnt;
      miss_next = miss_cnt;
      if (start_of_vsync) begin
         if (frame_hit) begin
            hit_next  = (hit_cnt == 4'd15) ? 4'd15 : hit_cnt + 4'd1;
            miss_next = '0;
         end else begin
            miss_next = (miss_cnt == 4'd15) ? 4'd15 : miss_cnt + 4'd1;
            hit_next  = '0;
         end
      end
   end

   // Controller FSM with registered outputs decoded for the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= IDLE;
         clear_enable  <= 1'b1;
         output_enable <= 1'b0;
         locked        <= 1'b0;
         lock_lost     <= 1'b0;
         stab_cnt      <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
         sof_seen      <= 1'b0;
      end else begin
         lock_lost <= 1'b0;
         if (!go) begin
            st            <= IDLE;
            clear_enable  <= 1'b1;
            output_enable <= 1'b0;
            locked        <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  st       <= WAIT_STABLE;
                  stab_cnt <= '0;
               end
               WAIT_STABLE: begin
                  if (!stable) begin
                     stab_cnt <= '0;
                  end else if (start_of_vsync) begin
                     stab_cnt <= stab_inc;
                     if (stab_inc >= 4'(STABLE_FRAMES)) begin
                        st            <= ARM;
                        output_enable <= 1'b1;
                     end
                  end
               end
               ARM: begin
                  st            <= ACQUIRE;
                  clear_enable  <= 1'b0;
                  output_enable <= 1'b1;
                  hit_cnt       <= '0;
                  miss_cnt      <= '0;
                  sof_seen      <= 1'b0;
               end
               ACQUIRE: begin
                  hit_cnt  <= hit_next;
                  miss_cnt <= miss_next;
                  sof_seen <= start_of_vsync ? 1'b0 : frame_hit;
                  if (!stable || miss_next >= 4'(TIMEOUT_FRAMES)) begin
                     st            <= RECOVER;
                     clear_enable  <= 1'b1;
                     output_enable <= 1'b0;
                  end else if (sof_locked && hit_next >= 4'(LOCK_FRAMES)) begin
                     st     <= LOCKED;
                     locked <= 1'b1;
                  end
               end
               LOCKED: begin
                  hit_cnt  <= hit_next;
                  miss_cnt <= miss_next;
                  sof_seen <= start_of_vsync ? 1'b0 : frame_hit;
                  if (!stable || !sof_locked || miss_next >= 4'(TIMEOUT_FRAMES)) begin
                     st            <= RECOVER;
                     clear_enable  <= 1'b1;
                     output_enable <= 1'b0;
                     locked        <= 1'b0;
                     lock_lost     <= 1'b1;
                  end
               end
               RECOVER: begin
                  st       <= WAIT_STABLE;
                  stab_cnt <= '0;
               end
               default: begin
                  st            <= IDLE;
                  clear_enable  <= 1'b1;
                  output_enable <= 1'b0;
                  locked        <= 1'b0;
               end
            endcase
         end
      end
   end

   assign shadow_wr = cfg_write && (cfg_addr <= 3'd3);
   assign commit    = pending && ((st == IDLE) || start_of_vsync);

   // Shadow/active configuration; a new write outranks the commit clearing pending
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_sample     <= '0;
         sh_line       <= '0;
         sh_subsample  <= '0;
         sh_divider    <= '0;
         sof_sample    <= '0;
         sof_line      <= '0;
         sof_subsample <= '0;
         divider_value <= '0;
         pending       <= 1'b0;
      end else begin
         if (commit) begin
            sof_sample    <= sh_sample;
            sof_line      <= sh_line;
            sof_subsample <= sh_subsample;
            divider_value <= sh_divider;
            pending       <= 1'b0;
         end
         if (shadow_wr) begin
            pending <= 1'b1;
            case (cfg_addr)
               3'd0:    sh_sample    <= cfg_wdata[13:0];
               3'd1:    sh_line      <= cfg_wdata[12:0];
               3'd2:    sh_divider   <= cfg_wdata[13:0];
               default: sh_subsample <= cfg_wdata[1:0];
            endcase
         end
      end
   end

`ifdef SYNC_LOCK_IRQ_EN
   // Sticky loss-of-lock interrupt; a new loss outranks a host clear
   always_ff @(posedge clk) begin
      if (rst) begin
         irq <= 1'b0;
      end else if (lock_lost) begin
         irq <= 1'b1;
      end else if (cfg_write && cfg_addr == 3'd4) begin
         irq <= 1'b0;
      end
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_alt_vipitc120_common_sync_lock_controller.sv
// Directed bench for the sync-lock controller: reset, stability qualification,
// arming, lock acquisition, config double-buffering, loss recovery and go=0.
module tb_alt_vipitc120_common_sync_lock_controller;

   logic        clk = 1'b0;
   logic        rst, go, cfg_write, stable, start_of_vsync, sof, sof_locked;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        clear_enable, output_enable, locked, lock_lost, irq;
   logic [13:0] sof_sample, divider_value;
   logic [12:0] sof_line;
   logic [1:0]  sof_subsample;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;
   logic exp_irq;

   always #5 clk = ~clk;

   alt_vipitc120_common_sync_lock_controller #(
      .STABLE_FRAMES(2), .LOCK_FRAMES(4), .TIMEOUT_FRAMES(8)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .cfg_write(cfg_write), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .stable(stable), .start_of_vsync(start_of_vsync),
      .sof(sof), .sof_locked(sof_locked), .clear_enable(clear_enable),
      .output_enable(output_enable), .sof_sample(sof_sample), .sof_line(sof_line),
      .sof_subsample(sof_subsample), .divider_value(divider_value), .locked(locked),
      .lock_lost(lock_lost), .state(state), .irq(irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
      cfg_write = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_write = 1'b0;
   endtask

   task automatic vsync();
      start_of_vsync = 1'b1;
      tick();
      start_of_vsync = 1'b0;
   endtask

   task automatic sof_pulse();
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      stable = 1'b0; start_of_vsync = 1'b0; sof = 1'b0; sof_locked = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_clear_enable", 16'(clear_enable), 16'd1);
      chk("rst_output_enable", 16'(output_enable), 16'd0);
      chk("rst_locked", 16'(locked), 16'd0);
      chk("rst_lock_lost", 16'(lock_lost), 16'd0);
      chk("rst_sof_line", 16'(sof_line), 16'd0);
      chk("rst_irq", 16'(irq), 16'd0);

      // IDLE commits directly; excess data bits dropped, addr 5 ignored
      cfg_wr(3'd0, 16'hFFFF);
      cfg_wr(3'd1, 16'h0ABC);
      cfg_wr(3'd3, 16'h0007);
      cfg_wr(3'd5, 16'h1234);
      tick(); tick();
      chk("idle_sof_sample", 16'(sof_sample), 16'h3FFF);
      chk("idle_sof_line", 16'(sof_line), 16'h0ABC);
      chk("idle_sof_subsample", 16'(sof_subsample), 16'h0003);
      chk("idle_divider", 16'(divider_value), 16'h0000);

      // Stability qualification with a dropout after the first vsync
      go = 1'b1;
      tick();
      chk("wait_state", 16'(state), 16'd1);
      chk("wait_clear_enable", 16'(clear_enable), 16'd1);
      stable = 1'b1;
      vsync(); tick();
      chk("wait_after_1", 16'(state), 16'd1);
      stable = 1'b0; tick(); stable = 1'b1; tick();
      vsync(); tick();
      chk("wait_after_drop_1", 16'(state), 16'd1);
      vsync();
      chk("arm_state", 16'(state), 16'd2);
      chk("arm_clear_enable", 16'(clear_enable), 16'd1);
      chk("arm_output_enable", 16'(output_enable), 16'd1);
      tick();
      chk("acq_state", 16'(state), 16'd3);
      chk("acq_clear_enable", 16'(clear_enable), 16'd0);
      chk("acq_output_enable", 16'(output_enable), 16'd1);

      // Four hit frames with sof_locked -> LOCKED
      sof_locked = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sof_pulse(); vsync();
      end
      chk("acq_after_3", 16'(state), 16'd3);
      chk("acq_locked_3", 16'(locked), 16'd0);
      sof_pulse(); vsync();
      chk("locked_state", 16'(state), 16'd4);
      chk("locked_flag", 16'(locked), 16'd1);

      // Double-buffered write in LOCKED commits on the next vsync
      cfg_wr(3'd1, 16'h0123);
      tick(); tick();
      chk("line_held", 16'(sof_line), 16'h0ABC);
      sof_pulse();
      start_of_vsync = 1'b1;
      chk("line_held_vsync", 16'(sof_line), 16'h0ABC);
      tick();
      start_of_vsync = 1'b0;
      chk("line_commit", 16'(sof_line), 16'h0123);
      chk("locked_hold", 16'(state), 16'd4);

      // Write coincident with a vsync that has nothing pending waits one frame
      sof_pulse();
      start_of_vsync = 1'b1; cfg_write = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'h1111;
      tick();
      start_of_vsync = 1'b0; cfg_write = 1'b0;
      tick();
      chk("coinc_held", 16'(sof_sample), 16'h3FFF);
      sof_pulse(); vsync();
      chk("coinc_commit", 16'(sof_sample), 16'h1111);

      // Eight frames without sof -> lock_lost, RECOVER, WAIT_STABLE
      for (int i = 0; i < 7; i++) begin
         vsync(); tick(); tick();
      end
      chk("miss7_state", 16'(state), 16'd4);
      chk("miss7_lock_lost", 16'(lock_lost), 16'd0);
      vsync();
      chk("recover_state", 16'(state), 16'd5);
      chk("recover_lock_lost", 16'(lock_lost), 16'd1);
      chk("recover_locked", 16'(locked), 16'd0);
      chk("recover_clear_enable", 16'(clear_enable), 16'd1);
      chk("recover_output_enable", 16'(output_enable), 16'd0);
      tick();
      chk("post_recover_state", 16'(state), 16'd1);
      chk("post_recover_pulse", 16'(lock_lost), 16'd0);
`ifdef SYNC_LOCK_IRQ_EN
      exp_irq = 1'b1;
`else
      exp_irq = 1'b0;
`endif
      chk("irq_after_loss", 16'(irq), 16'(exp_irq));
      tick();
      chk("irq_held", 16'(irq), 16'(exp_irq));
      cfg_wr(3'd4, 16'h0000);
      tick();
      chk("irq_cleared", 16'(irq), 16'd0);

      // Re-arm, then go=0 mid-ACQUIRE with a pending divider write
      vsync(); tick(); vsync();
      chk("rearm_state", 16'(state), 16'd2);
      tick();
      chk("reacq_state", 16'(state), 16'd3);
      cfg_wr(3'd2, 16'h2345);
      tick();
      chk("div_held_acq", 16'(divider_value), 16'h0000);
      go = 1'b0;
      tick();
      chk("go0_state", 16'(state), 16'd0);
      chk("go0_clear_enable", 16'(clear_enable), 16'd1);
      chk("go0_output_enable", 16'(output_enable), 16'd0);
      tick(); tick();
      chk("go0_div_commit", 16'(divider_value), 16'h2345);
      chk("go0_line_kept", 16'(sof_line), 16'h0123);

      // stable loss in ACQUIRE recovers without a lock_lost pulse
      go = 1'b1;
      tick();
      vsync(); tick(); vsync(); tick();
      chk("acq2_state", 16'(state), 16'd3);
      stable = 1'b0;
      tick();
      chk("acq_unstable_state", 16'(state), 16'd5);
      chk("acq_unstable_pulse", 16'(lock_lost), 16'd0);
      tick();
      chk("acq_unstable_wait", 16'(state), 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
